// File: rtl/can_rx_fifo.sv
// Receive message FIFO for a CAN controller: acceptance filtering, DLC/RTR data masking,
// show-ahead head-of-queue outputs, sticky overrun and a write interrupt pulse.
module can_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_done_flag,
    input  logic [10:0]              rx_id_std,
    input  logic [17:0]              rx_id_ext,
    input  logic                     rx_ide,
    input  logic                     rx_remote_req,
    input  logic [3:0]               rx_dlc,
    input  logic [63:0]              rx_data,
    input  logic                     filter_en,
    input  logic [28:0]              acc_code,
    input  logic [28:0]              acc_mask,
    input  logic                     rd_en,
    input  logic                     clr_overrun,
    output logic                     msg_valid,
    output logic [10:0]              out_id_std,
    output logic [17:0]              out_id_ext,
    output logic                     out_ide,
    output logic                     out_rtr,
    output logic [3:0]               out_dlc,
    output logic [63:0]              out_data,
    output logic [$clog2(DEPTH):0]   msg_count,
    output logic                     fifo_full,
    output logic                     overrun,
    output logic                     rx_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [10:0] memStd_q  [DEPTH];
    logic [17:0] memExt_q  [DEPTH];
    logic        memIde_q  [DEPTH];
    logic        memRtr_q  [DEPTH];
    logic [3:0]  memDlc_q  [DEPTH];
    logic [63:0] memData_q [DEPTH];

    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          irq_q, irq_d;

    logic [28:0] cmpId;
    logic        accepted;
    logic        isEmpty;
    logic        isFull;
    logic        wrEn;
    logic        popEn;
    logic        dropEn;
    logic [63:0] dataMasked;

    // Standard frames are compared with a zeroed extension so a single 29-bit code/mask covers both formats.
    assign cmpId    = rx_ide ? {rx_id_std, rx_id_ext} : {rx_id_std, 18'b0};
    assign accepted = !filter_en || (((cmpId ^ acc_code) & acc_mask) == 29'b0);

    assign isEmpty = (count_q == '0);
    assign isFull  = (count_q == FULL_COUNT);
    assign popEn   = rd_en && !isEmpty;
    assign wrEn    = rx_done_flag && accepted && (!isFull || rd_en);
    assign dropEn  = rx_done_flag && accepted && isFull && !rd_en;

    always_comb begin
        dataMasked = '0;
        for (int n = 0; n < 8; n++) begin
            if (!rx_remote_req && (4'(n) < rx_dlc)) begin
                dataMasked[8*n +: 8] = rx_data[8*n +: 8];
            end
        end
    end

    always_comb begin
        wrPtr_d   = wrEn  ? wrPtr_q + 1'b1 : wrPtr_q;
        rdPtr_d   = popEn ? rdPtr_q + 1'b1 : rdPtr_q;
        count_d   = count_q;
        if (wrEn && !popEn) begin
            count_d = count_q + 1'b1;
        end else if (popEn && !wrEn) begin
            count_d = count_q - 1'b1;
        end
        // A new loss wins over a same-cycle clear so no overrun event is ever missed.
        overrun_d = dropEn || (overrun_q && !clr_overrun);
        irq_d     = wrEn;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
        end
    end

    // Slot storage is not reset; emptiness is tracked by the counter alone.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            memStd_q[wrPtr_q]  <= rx_id_std;
            memExt_q[wrPtr_q]  <= rx_id_ext;
            memIde_q[wrPtr_q]  <= rx_ide;
            memRtr_q[wrPtr_q]  <= rx_remote_req;
            memDlc_q[wrPtr_q]  <= rx_dlc;
            memData_q[wrPtr_q] <= dataMasked;
        end
    end

    assign msg_valid  = !isEmpty;
    assign msg_count  = count_q;
    assign fifo_full  = isFull;
    assign overrun    = overrun_q;
    assign rx_irq     = irq_q;

    assign out_id_std = msg_valid ? memStd_q[rdPtr_q]  : '0;
    assign out_id_ext = msg_valid ? memExt_q[rdPtr_q]  : '0;
    assign out_ide    = msg_valid ? memIde_q[rdPtr_q]  : 1'b0;
    assign out_rtr    = msg_valid ? memRtr_q[rdPtr_q]  : 1'b0;
    assign out_dlc    = msg_valid ? memDlc_q[rdPtr_q]  : '0;
    assign out_data   = msg_valid ? memData_q[rdPtr_q] : '0;

endmodule

// File: tb/tb_can_rx_fifo.sv
// Directed self-checking bench for can_rx_fifo (DEPTH = 4): filtering, masking, overrun,
// full-with-pop, remote frames, reset and pointer wrap.
module tb_can_rx_fifo;

    logic        clk;
    logic        rst;
    logic        rx_done_flag;
    logic [10:0] rx_id_std;
    logic [17:0] rx_id_ext;
    logic        rx_ide;
    logic        rx_remote_req;
    logic [3:0]  rx_dlc;
    logic [63:0] rx_data;
    logic        filter_en;
    logic [28:0] acc_code;
    logic [28:0] acc_mask;
    logic        rd_en;
    logic        clr_overrun;
    logic        msg_valid;
    logic [10:0] out_id_std;
    logic [17:0] out_id_ext;
    logic        out_ide;
    logic        out_rtr;
    logic [3:0]  out_dlc;
    logic [63:0] out_data;
    logic [2:0]  msg_count;
    logic        fifo_full;
    logic        overrun;
    logic        rx_irq;

    int testCount = 0;
    int failCount = 0;

    can_rx_fifo #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rx_done_flag(rx_done_flag),
        .rx_id_std(rx_id_std), .rx_id_ext(rx_id_ext), .rx_ide(rx_ide),
        .rx_remote_req(rx_remote_req), .rx_dlc(rx_dlc), .rx_data(rx_data),
        .filter_en(filter_en), .acc_code(acc_code), .acc_mask(acc_mask),
        .rd_en(rd_en), .clr_overrun(clr_overrun), .msg_valid(msg_valid),
        .out_id_std(out_id_std), .out_id_ext(out_id_ext), .out_ide(out_ide),
        .out_rtr(out_rtr), .out_dlc(out_dlc), .out_data(out_data),
        .msg_count(msg_count), .fifo_full(fifo_full), .overrun(overrun), .rx_irq(rx_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One cycle of stimulus driven at a falling edge; results are sampled at the next falling edge.
    task automatic applyStimulus(input logic done, input logic [10:0] std, input logic [17:0] ext,
                                 input logic ide, input logic rtr, input logic [3:0] dlc,
                                 input logic [63:0] data, input logic rd, input logic clr);
        @(negedge clk);
        rx_done_flag  = done;
        rx_id_std     = std;
        rx_id_ext     = ext;
        rx_ide        = ide;
        rx_remote_req = rtr;
        rx_dlc        = dlc;
        rx_data       = data;
        rd_en         = rd;
        clr_overrun   = clr;
        @(negedge clk);
        rx_done_flag  = 1'b0;
        rd_en         = 1'b0;
        clr_overrun   = 1'b0;
    endtask

    task automatic pushStd(input logic [10:0] std, input logic [3:0] dlc, input logic [63:0] data);
        applyStimulus(1'b1, std, 18'h0, 1'b0, 1'b0, dlc, data, 1'b0, 1'b0);
    endtask

    task automatic popOne();
        applyStimulus(1'b0, 11'h0, 18'h0, 1'b0, 1'b0, 4'h0, 64'h0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        rx_done_flag = 0; rx_id_std = 0; rx_id_ext = 0; rx_ide = 0; rx_remote_req = 0;
        rx_dlc = 0; rx_data = 0; filter_en = 0; acc_code = 0; acc_mask = 0;
        rd_en = 0; clr_overrun = 0;

        repeat (2) @(negedge clk);
        checkOutput("rst_count",   64'(msg_count), 64'd0);
        checkOutput("rst_valid",   64'(msg_valid), 64'd0);
        checkOutput("rst_full",    64'(fifo_full), 64'd0);
        checkOutput("rst_overrun", 64'(overrun),   64'd0);
        checkOutput("rst_irq",     64'(rx_irq),    64'd0);
        checkOutput("rst_data",    out_data,       64'd0);
        rst = 1'b0;

        // Unfiltered standard frame with dlc 2: only the low two bytes survive.
        pushStd(11'h123, 4'd2, 64'h1122_3344_5566_AABB);
        checkOutput("basic_valid", 64'(msg_valid),  64'd1);
        checkOutput("basic_id",    64'(out_id_std), 64'h123);
        checkOutput("basic_data",  out_data,        64'h0000_0000_0000_AABB);
        checkOutput("basic_dlc",   64'(out_dlc),    64'd2);
        checkOutput("basic_irq",   64'(rx_irq),     64'd1);
        checkOutput("basic_count", 64'(msg_count),  64'd1);
        @(negedge clk);
        checkOutput("irq_one_cycle", 64'(rx_irq), 64'd0);
        popOne();
        checkOutput("pop_empty_count", 64'(msg_count), 64'd0);
        checkOutput("pop_empty_data",  out_data,       64'd0);

        // Acceptance filter on std bits [10:4].
        filter_en = 1'b1;
        acc_code  = {11'h120, 18'h0};
        acc_mask  = {11'h7F0, 18'h0};
        pushStd(11'h12F, 4'd8, 64'hDEAD_BEEF_0123_4567);
        pushStd(11'h130, 4'd1, 64'h55);
        checkOutput("filt_count",   64'(msg_count),  64'd1);
        checkOutput("filt_head",    64'(out_id_std), 64'h12F);
        checkOutput("filt_data8",   out_data,        64'hDEAD_BEEF_0123_4567);
        checkOutput("filt_rej_irq", 64'(rx_irq),     64'd0);
        checkOutput("filt_rej_ovr", 64'(overrun),    64'd0);
        popOne();

        // Extension bits only take part in the compare for extended frames.
        acc_code = {11'h120, 18'h00005};
        acc_mask = 29'h1FFF_FFFF;
        applyStimulus(1'b1, 11'h120, 18'h00005, 1'b1, 1'b0, 4'd0, 64'hFF, 1'b0, 1'b0);
        applyStimulus(1'b1, 11'h120, 18'h00005, 1'b0, 1'b0, 4'd0, 64'hFF, 1'b0, 1'b0);
        checkOutput("ext_count", 64'(msg_count),  64'd1);
        checkOutput("ext_id",    64'(out_id_ext), 64'h5);
        checkOutput("ext_ide",   64'(out_ide),    64'd1);
        checkOutput("ext_dlc0",  out_data,        64'd0);
        popOne();
        filter_en = 1'b0;

        // Fill, then overflow.
        for (int i = 1; i <= 4; i++) pushStd(11'(i), 4'd1, 64'(i));
        checkOutput("full_flag",  64'(fifo_full), 64'd1);
        checkOutput("full_count", 64'(msg_count), 64'd4);
        pushStd(11'h5, 4'd1, 64'h5);
        checkOutput("ovr_flag",  64'(overrun),    64'd1);
        checkOutput("ovr_irq",   64'(rx_irq),     64'd0);
        checkOutput("ovr_count", 64'(msg_count),  64'd4);
        checkOutput("ovr_head",  64'(out_id_std), 64'h1);
        applyStimulus(1'b0, 11'h0, 18'h0, 1'b0, 1'b0, 4'h0, 64'h0, 1'b0, 1'b1);
        checkOutput("ovr_clear", 64'(overrun), 64'd0);
        applyStimulus(1'b1, 11'h6, 18'h0, 1'b0, 1'b0, 4'd1, 64'h6, 1'b0, 1'b1);
        checkOutput("ovr_set_wins", 64'(overrun), 64'd1);
        applyStimulus(1'b0, 11'h0, 18'h0, 1'b0, 1'b0, 4'h0, 64'h0, 1'b0, 1'b1);
        checkOutput("ovr_clear2", 64'(overrun), 64'd0);

        // Full with a same-cycle pop: the new frame is written, no loss.
        applyStimulus(1'b1, 11'h7, 18'h0, 1'b0, 1'b0, 4'd1, 64'h77, 1'b1, 1'b0);
        checkOutput("fullpop_count", 64'(msg_count),  64'd4);
        checkOutput("fullpop_ovr",   64'(overrun),    64'd0);
        checkOutput("fullpop_irq",   64'(rx_irq),     64'd1);
        checkOutput("fullpop_head",  64'(out_id_std), 64'h2);
        popOne();
        popOne();
        checkOutput("fullpop_head4", 64'(out_id_std), 64'h4);
        popOne();
        checkOutput("fullpop_new_id",   64'(out_id_std), 64'h7);
        checkOutput("fullpop_new_data", out_data,        64'h77);
        popOne();
        checkOutput("drain_empty", 64'(msg_valid), 64'd0);

        // Remote frame carries no data; dlc kept as received.
        applyStimulus(1'b1, 11'h3A5, 18'h0, 1'b0, 1'b1, 4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        checkOutput("rtr_flag", 64'(out_rtr), 64'd1);
        checkOutput("rtr_dlc",  64'(out_dlc), 64'd8);
        checkOutput("rtr_data", out_data,     64'd0);
        popOne();
        popOne();
        checkOutput("empty_rd_count", 64'(msg_count), 64'd0);
        checkOutput("empty_rd_valid", 64'(msg_valid), 64'd0);

        // dlc above 8 keeps all bytes and is stored unmodified.
        pushStd(11'h0F0, 4'd15, 64'h0102_0304_0506_0708);
        checkOutput("dlc15_dlc",  64'(out_dlc), 64'd15);
        checkOutput("dlc15_data", out_data,     64'h0102_0304_0506_0708);
        pushStd(11'h0F1, 4'd1, 64'h99);
        checkOutput("pre_rst_count", 64'(msg_count), 64'd2);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_count", 64'(msg_count),  64'd0);
        checkOutput("midrst_valid", 64'(msg_valid),  64'd0);
        checkOutput("midrst_id",    64'(out_id_std), 64'd0);
        checkOutput("midrst_data",  out_data,        64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Six write+pop cycles at occupancy 1 walk both pointers past the wrap.
        pushStd(11'h040, 4'd1, 64'h40);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 11'(12'h040 + i), 18'h0, 1'b0, 1'b0, 4'd1, 64'(8'h40 + i), 1'b1, 1'b0);
            checkOutput($sformatf("wrap_head_%0d", i), 64'(out_id_std), 64'(12'h040 + i));
            checkOutput($sformatf("wrap_count_%0d", i), 64'(msg_count), 64'd1);
        end
        pushStd(11'h050, 4'd1, 64'h50);
        checkOutput("wrap_count2", 64'(msg_count), 64'd2);
        popOne();
        checkOutput("wrap_tail", 64'(out_id_std), 64'h050);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/can_rx_fifo.md
CAN_RX_FIFO -- requirements
Module: can_rx_fifo

Interface
REQ-001 Parameter: DEPTH, 4, number of message slots; power of two, 2..16.
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-high reset.
REQ-004 Port: rx_done_flag  in  1  one-cycle pulse from receiver: a complete frame is present on the rx_* inputs.
REQ-005 Port: rx_id_std  in  11  received base identifier.
REQ-006 Port: rx_id_ext  in  18  received identifier extension.
REQ-007 Port: rx_ide  in  1  1 = extended frame.
REQ-008 Port: rx_remote_req  in  1  1 = remote frame.
REQ-009 Port: rx_dlc  in  4  received data length code.
REQ-010 Port: rx_data  in  64  data bytes; byte n on bits [8n+7:8n].
REQ-011 Port: filter_en  in  1  1 = apply acceptance filter; 0 = accept all frames.
REQ-012 Port: acc_code  in  29  acceptance code, {id_std, id_ext}.
REQ-013 Port: acc_mask  in  29  acceptance mask; bit = 1 means compare that bit.
REQ-014 Port: rd_en  in  1  pop the head message.
REQ-015 Port: clr_overrun  in  1  clears the overrun flag.
REQ-016 Port: msg_valid  out  1  FIFO not empty.
REQ-017 Port: out_id_std, out_id_ext, out_ide, out_rtr, out_dlc, out_data  out  11/18/1/1/4/64  head message fields.
REQ-018 Port: msg_count  out  $clog2(DEPTH)+1  messages stored.
REQ-019 Port: fifo_full  out  1  msg_count == DEPTH.
REQ-020 Port: overrun  out  1  sticky: an accepted frame was lost.
REQ-021 Port: rx_irq  out  1  one-cycle pulse, registered, on each successful write.

Function
REQ-022 Compare id SHALL be {rx_id_std, rx_id_ext} when rx_ide = 1, else {rx_id_std, 18'b0}.
REQ-023 A frame SHALL be accepted when filter_en = 0, or when ((id ^ acc_code) & acc_mask) == 0.
REQ-024 Write condition: rx_done_flag & accepted & (not full, or rd_en asserted the same cycle while full).
REQ-025 Data written into a slot SHALL have byte n forced to 0 for n >= min(rx_dlc, 8); when rx_remote_req = 1, all bytes SHALL be 0. rx_dlc SHALL be stored unmodified.
REQ-026 Written entry SHALL be visible at the outputs one cycle after the rx_done_flag cycle; msg_count updates in the same edge.
REQ-027 The outputs SHALL be show-ahead: out_* reflect the head slot whenever msg_valid = 1, and are all-zero when empty.
REQ-028 rd_en with msg_valid = 1 SHALL pop the head at the edge; rd_en while empty SHALL be ignored, with no state change.
REQ-029 Simultaneous write and pop SHALL leave msg_count unchanged and advance both pointers.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 Accepted frame while full without a same-cycle pop SHALL be dropped, storage unchanged, overrun set to 1 next edge.
REQ-032 Rejected frames SHALL cause no state change and no overrun.
REQ-033 overrun SHALL stay 1 until clr_overrun; if clr_overrun and a new overrun occur in the same cycle, overrun SHALL remain 1.
REQ-034 rx_irq SHALL be 1 for exactly the cycle after each successful write; it SHALL be 0 for dropped and rejected frames.

Reset
REQ-035 While rst = 1: pointers and msg_count = 0, msg_valid = 0, fifo_full = 0, overrun = 0, rx_irq = 0, all out_* = 0.
REQ-036 Reset asserted mid-operation SHALL discard all stored messages; slot contents need not be cleared.

Verification
REQ-037 filter_en = 0: std id 0x123, dlc 2, data 0xAABB -> next cycle msg_valid = 1, out_id_std = 0x123, out_data = 0x...0000AABB with upper 6 bytes 0, rx_irq pulse.
REQ-038 filter_en = 1, acc_code std 0x120, mask compares std bits [10:4]: id 0x12F accepted, id 0x130 rejected -> msg_count = 1.
REQ-039 Write 4 frames, then a 5th -> fifo_full = 1, overrun = 1, head unchanged; clr_overrun -> overrun = 0.
REQ-040 Full FIFO, rd_en and a new frame in the same cycle -> msg_count stays 4, no overrun, new frame appears after 3 pops.
REQ-041 Remote frame with dlc 8 and nonzero rx_data -> out_rtr = 1, out_dlc = 8, out_data = 0; rd_en while empty -> no change.
REQ-042 Two frames stored, assert rst -> msg_count = 0, outputs 0; 6 write/pop cycles after release verify pointer wrap.
